mips_program_loader: RTL
========================

// Module: mips_program_loader
// PURPOSE
//  Boot-time program loader directly upstream of the mips_32 core. Receives a byte stream
//  over a valid/ready link, assembles big-endian 32-bit words and writes them into the core's
//  unified memory, then releases the core from hold. Replaces bench-side direct mem[] pokes.
//  Single clock domain, running on the core's phase-1 clock.
// PARAMETERS
//  AW         8    word-address width of the core memory
//  MEM_DEPTH  256  words addressable, always equal to 1<<AW
// PORTS
//  clock1       in   1   clock, the core's phase-1 clock
//  reset_n      in   1   synchronous reset, active-low
//  load_req     in   1   one-cycle pulse: re-arm the loader (honoured only in DONE/ERROR)
//  rx_data      in   8   stream byte
//  rx_valid     in   1   rx_data is valid
//  rx_ready     out  1   loader accepts a byte; a byte transfers when rx_valid & rx_ready
//  mem_we       out  1   memory write strobe, one cycle per word
//  mem_addr     out  AW  word address of the write
//  mem_wdata    out  32  word being written
//  cpu_hold     out  1   while 1, the core holds pc=0, halted=1, taken_branch=0
//  cpu_start    out  1   one-cycle pulse when the core is released
//  load_done    out  1   sticky: image loaded and checksum good
//  cksum_err    out  1   sticky: checksum mismatch
//  ovf_err      out  1   sticky: base+count > MEM_DEPTH
// BEHAVIOUR
//  Stream format: BASE[4] COUNT[4] PAYLOAD[4*COUNT] CKSUM[1]. All fields big-endian.
//   CKSUM is the XOR of all payload bytes.
//  Reset (reset_n=0 at a clock1 edge): state=HDR_BASE. rx_ready=0 that cycle.
//   Outputs: mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, cpu_start=0, all flags=0.
//   Byte counters, checksum accumulator and word count are cleared.
//   Memory already written is not cleared. Reset mid-load aborts at once; no further write.
//  States:
//   HDR_BASE  rx_ready=1. Take 4 bytes; base=low AW bits of the word.
//   HDR_CNT   rx_ready=1. Take 4 bytes, giving cnt (32-bit).
//             If base+cnt > MEM_DEPTH (compare at 33-bit width) -> ERROR, ovf_err=1.
//             Else if cnt==0 -> CKSUM, else -> PAYLOAD.
//   PAYLOAD   rx_ready=1. Every byte is XORed into acc.
//             The cycle after the 4th byte of a word is accepted: mem_we=1,
//              mem_addr=base+i, mem_wdata=assembled word (byte0 in [31:24]), i++.
//             Byte acceptance continues in that write cycle (no bubble).
//             After the last word's write cycle -> CKSUM.
//   CKSUM     rx_ready=1. Take 1 byte. If equal to acc -> RELEASE, else -> ERROR with cksum_err=1.
//   RELEASE   one cycle: cpu_hold=0, cpu_start=1, load_done=1 -> DONE.
//   DONE      rx_ready=0, cpu_hold=0. On load_req: cpu_hold=1, clear flags and acc -> HDR_BASE.
//   ERROR     rx_ready=0, cpu_hold=1. On load_req: clear flags and acc -> HDR_BASE.
//  load_req in any other state is ignored. A byte presented with rx_ready=0 is not consumed.
//  rx_valid may drop mid-word: assembly pauses and latency stretches, no data lost.
//  Address never wraps: the overflow check guarantees base+i <= MEM_DEPTH-1.
//  Latency: last CKSUM byte accepted at edge N -> cpu_start high in cycle N+1.
// STRUCTURE
//  mips_loader_pkg: state enum (HDR_BASE, HDR_CNT, PAYLOAD, CKSUM, RELEASE, DONE, ERROR),
//   HDR_BYTES=4, CKSUM_BYTES=1.
//  One sub-module, byte_word_assembler: 2-bit byte index, 32-bit shift register,
//   word_valid pulse, clear input.
//  FSM, address counter, XOR accumulator and error flags live in the top level.
// TESTING
//  1 Stream 00000000 00000001 28 0a 00 c8 ea -> one write addr 0 data 280a00c8;
//    cpu_start pulse; load_done=1.
//  2 Stream BASE=0x0A, CNT=1, payload fc000000, CKSUM fc
//    -> write addr 10 data fc000000; cpu_hold falls the cycle cpu_start rises.
//  3 Same as 1 with CKSUM=0x00 -> cksum_err=1, cpu_hold stays 1, no cpu_start;
//    load_req -> back in HDR_BASE with flags cleared.
//  4 BASE=0xFE, CNT=3 -> ovf_err=1 after the 8th byte, zero mem_we pulses, rx_ready=0.
//  5 CNT=0, CKSUM=00 -> no writes; cpu_start exactly one cycle after the CKSUM byte.
//  6 reset_n low after 2 of 4 bytes of word 2 -> word 2 never written;
//    reload to same base rewrites correctly.
//    Also: random rx_valid gaps must give the same write sequence.

Source files
------------

// File: rtl/mips_loader_pkg.sv
// Shared types for the boot-time program loader: FSM states, stream field sizes
// and small state-classification helpers.
package mips_loader_pkg;

  localparam int HDR_BYTES   = 4;
  localparam int CKSUM_BYTES = 1;

  typedef enum logic [2:0] {
    HDR_BASE,
    HDR_CNT,
    PAYLOAD,
    CKSUM,
    RELEASE,
    DONE,
    ERROR
  } state_t;

  // States in which the link is open for bytes.
  function automatic logic takes_bytes(input state_t s);
    return s inside {HDR_BASE, HDR_CNT, PAYLOAD, CKSUM};
  endfunction

  // States whose bytes are packed into big-endian 32-bit words.
  function automatic logic builds_words(input state_t s);
    return s inside {HDR_BASE, HDR_CNT, PAYLOAD};
  endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// Packs a byte stream into big-endian 32-bit words; word/word_valid present the
// completed word in the same cycle its fourth byte is accepted.
module byte_word_assembler
  import mips_loader_pkg::*;
(
  input  logic        clock1,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  idx_reg;
  logic [23:0] shift_reg;

  // The first three bytes are held; the fourth completes the word directly.
  assign word       = {shift_reg, byte_in};
  assign word_valid = byte_en && (idx_reg == 2'(HDR_BYTES - 1));

  always_ff @(posedge clock1) begin
    if (!reset_n || clear) begin
      idx_reg   <= '0;
      shift_reg <= '0;
    end else if (byte_en) begin
      idx_reg   <= idx_reg + 2'd1;
      shift_reg <= {shift_reg[15:0], byte_in};
    end
  end

endmodule

// File: rtl/mips_program_loader.sv
// Boot loader in front of the mips_32 core: parses BASE/COUNT/PAYLOAD/CKSUM from a
// byte stream, writes words into core memory, then releases the core from hold.
module mips_program_loader
  import mips_loader_pkg::*;
#(
  parameter int AW        = 8,
  parameter int MEM_DEPTH = 1 << AW
) (
  input  logic          clock1,
  input  logic          reset_n,
  input  logic          load_req,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          cpu_hold,
  output logic          cpu_start,
  output logic          load_done,
  output logic          cksum_err,
  output logic          ovf_err
);

  state_t        state_reg;
  logic          rx_ready_reg;
  logic          mem_we_reg;
  logic [AW-1:0] mem_addr_reg;
  logic [31:0]   mem_wdata_reg;
  logic          cpu_hold_reg;
  logic          cpu_start_reg;
  logic          load_done_reg;
  logic          cksum_err_reg;
  logic          ovf_err_reg;
  logic [AW-1:0] base_reg;
  logic [31:0]   cnt_reg;
  logic [31:0]   widx_reg;
  logic [7:0]    acc_reg;

  logic          accept;
  logic          asm_clear;
  logic          word_valid;
  logic [31:0]   word;
  logic [32:0]   span;

  assign accept    = rx_valid && rx_ready_reg;
  assign asm_clear = load_req && (state_reg == DONE || state_reg == ERROR);
  // 33-bit sum so a huge COUNT cannot wrap past the memory-depth check.
  assign span      = 33'(base_reg) + {1'b0, word};

  byte_word_assembler u_asm (
    .clock1     (clock1),
    .reset_n    (reset_n),
    .clear      (asm_clear),
    .byte_en    (accept && builds_words(state_reg)),
    .byte_in    (rx_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clock1) begin
    if (!reset_n) begin
      state_reg     <= HDR_BASE;
      rx_ready_reg  <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      cpu_hold_reg  <= 1'b1;
      cpu_start_reg <= 1'b0;
      load_done_reg <= 1'b0;
      cksum_err_reg <= 1'b0;
      ovf_err_reg   <= 1'b0;
      base_reg      <= '0;
      cnt_reg       <= '0;
      widx_reg      <= '0;
      acc_reg       <= '0;
    end else begin
      mem_we_reg    <= 1'b0;
      cpu_start_reg <= 1'b0;
      rx_ready_reg  <= takes_bytes(state_reg);
      case (state_reg)
        HDR_BASE: begin
          if (word_valid) begin
            base_reg  <= word[AW-1:0];
            state_reg <= HDR_CNT;
          end
        end
        HDR_CNT: begin
          if (word_valid) begin
            cnt_reg  <= word;
            widx_reg <= '0;
            if (span > 33'(MEM_DEPTH)) begin
              ovf_err_reg  <= 1'b1;
              state_reg    <= ERROR;
              rx_ready_reg <= 1'b0;
            end else if (word == 32'd0) begin
              state_reg <= CKSUM;
            end else begin
              state_reg <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (accept) acc_reg <= acc_reg ^ rx_data;
          // The final word's write cycle overlaps CKSUM so the checksum byte needs no bubble.
          if (word_valid) begin
            mem_we_reg    <= 1'b1;
            mem_addr_reg  <= base_reg + widx_reg[AW-1:0];
            mem_wdata_reg <= word;
            widx_reg      <= widx_reg + 32'd1;
            if (widx_reg + 32'd1 == cnt_reg) state_reg <= CKSUM;
          end
        end
        CKSUM: begin
          if (accept) begin
            rx_ready_reg <= 1'b0;
            if (rx_data == acc_reg) begin
              state_reg     <= RELEASE;
              cpu_hold_reg  <= 1'b0;
              cpu_start_reg <= 1'b1;
              load_done_reg <= 1'b1;
            end else begin
              state_reg     <= ERROR;
              cksum_err_reg <= 1'b1;
            end
          end
        end
        RELEASE: begin
          state_reg <= DONE;
        end
        DONE, ERROR: begin
          if (load_req) begin
            cpu_hold_reg  <= 1'b1;
            load_done_reg <= 1'b0;
            cksum_err_reg <= 1'b0;
            ovf_err_reg   <= 1'b0;
            acc_reg       <= '0;
            state_reg     <= HDR_BASE;
            rx_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg    <= HDR_BASE;
          rx_ready_reg <= 1'b0;
        end
      endcase
    end
  end

  assign rx_ready  = rx_ready_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign cpu_hold  = cpu_hold_reg;
  assign cpu_start = cpu_start_reg;
  assign load_done = load_done_reg;
  assign cksum_err = cksum_err_reg;
  assign ovf_err   = ovf_err_reg;

endmodule
